bus_cycle_master: RTL and testbench

BUS_CYCLE_MASTER -- requirements
Module: bus_cycle_master

---
 rtl/bus_cycle_master.sv | 170 +++++++++++++++++
 tb/tb_bus_cycle_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_master.sv
// bus_cycle_master: runs one asynchronous-bus word cycle at a time.
// A request is latched in IDLE, then the FSM walks through address setup,
// strobe assertion, a wait for the synchronized DTACK (with an optional timeout),
// strobe release, and a recovery phase. The recovery phase holds until the
// decoder drops DTACK again.
// Every bus-side output and status pulse is a register. Each one is loaded on the
// clock edge that enters the state it belongs to.
//
// Handshake: a request is taken only when o_busy=0 and i_req=1 at a rising edge.
// The cycle then finishes with exactly one o_ack or o_berr pulse. While o_busy=1
// the block ignores i_req. A request held high is taken again only after
// RECOVER returns to IDLE.
`timescale 1ns/1ps
module bus_cycle_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [22:0] i_addr,
  input  logic [1:0]  i_be,
  input  logic [15:0] i_wdata,
  output logic        o_ack,
  output logic        o_berr,
  output logic [15:0] o_rdata,
  output logic        o_busy,
  output logic [22:0] o_A,
  output logic        o_AS_n,
  output logic        o_UDS_n,
  output logic        o_LDS_n,
  output logic        o_RW,
  output logic [15:0] o_D,
  output logic        o_D_oe,
  input  logic [15:0] i_D,
  input  logic        i_DTACK_n,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_STROBE  = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  // Counter is wide enough to reach TIMEOUT_CYCLES.
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] TMO = (CW + 1)'(TIMEOUT_CYCLES);

  state_t        state;
  logic          we_r;
  logic [1:0]    be_r;
  logic [CW-1:0] wait_cnt;
  logic [CW:0]   cnt_inc;
  logic          dtack_ff1;
  logic          dtack_ff2;
  logic          dtack_s;
  logic          timeout_hit;

  assign dtack_s     = dtack_ff2;
  assign cnt_inc     = {1'b0, wait_cnt} + (CW + 1)'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);
  assign o_state     = state;

  // Bus cycle sequencer, DTACK synchronizer and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      we_r      <= 1'b0;
      be_r      <= 2'b00;
      wait_cnt  <= '0;
      dtack_ff1 <= 1'b1;
      dtack_ff2 <= 1'b1;
      o_ack     <= 1'b0;
      o_berr    <= 1'b0;
      o_busy    <= 1'b0;
      o_rdata   <= 16'h0000;
      o_A       <= 23'h000000;
      o_D       <= 16'h0000;
      o_D_oe    <= 1'b0;
      o_RW      <= 1'b1;
      o_AS_n    <= 1'b1;
      o_UDS_n   <= 1'b1;
      o_LDS_n   <= 1'b1;
    end else begin
      dtack_ff1 <= i_DTACK_n;
      dtack_ff2 <= dtack_ff1;
      o_ack     <= 1'b0;
      o_berr    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req) begin
            if (i_be == 2'b00) begin
              // A request with no byte lanes is rejected without touching the bus.
              o_berr <= 1'b1;
            end else begin
              we_r     <= i_we;
              be_r     <= i_be;
              o_A      <= i_addr;
              o_D      <= i_we ? i_wdata : 16'h0000;
              o_D_oe   <= i_we;
              o_RW     <= ~i_we;
              o_busy   <= 1'b1;
              wait_cnt <= '0;
              state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          // Reads assert the data strobes together with AS. Writes delay them
          // by one cycle so the data is valid before the strobes.
          o_AS_n <= 1'b0;
          if (!we_r) begin
            o_UDS_n <= ~be_r[1];
            o_LDS_n <= ~be_r[0];
          end
          state <= S_STROBE;
        end
        S_STROBE: begin
          o_UDS_n <= ~be_r[1];
          o_LDS_n <= ~be_r[0];
          state   <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= cnt_inc[CW-1:0];
          if (!dtack_s) begin
            // DTACK wins over a timeout that expires in the same cycle.
            if (!we_r) o_rdata <= i_D;
            o_ack   <= 1'b1;
            o_AS_n  <= 1'b1;
            o_UDS_n <= 1'b1;
            o_LDS_n <= 1'b1;
            state   <= S_RELEASE;
          end else if (timeout_hit) begin
            o_berr  <= 1'b1;
            o_AS_n  <= 1'b1;
            o_UDS_n <= 1'b1;
            o_LDS_n <= 1'b1;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Write data is held through RELEASE and dropped on entry to RECOVER.
          o_D_oe <= 1'b0;
          o_RW   <= 1'b1;
          state  <= S_RECOVER;
        end
        S_RECOVER: begin
          if (dtack_s) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          o_AS_n  <= 1'b1;
          o_UDS_n <= 1'b1;
          o_LDS_n <= 1'b1;
          o_D_oe  <= 1'b0;
          o_RW    <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bench for bus_cycle_master. Cycle 0 is the cycle in which i_req
// is presented. Inputs change 1 ns after a rising edge. Outputs are sampled
// at that point and at falling edges.
`timescale 1ns/1ps
module tb_bus_cycle_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [22:0] addr = '0;
  logic [1:0]  be = 2'b00;
  logic [15:0] wdata = '0;
  logic [15:0] bus_d = '0;
  logic        dtack_n = 1'b1;
  logic        ack, berr, busy, as_n, uds_n, lds_n, rw, d_oe;
  logic [15:0] rdata, bus_q;
  logic [22:0] bus_a;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {ack, berr, rdata}.
  logic [17:0] exp_q[$];
  logic [15:0] model_rdata = 16'h0000;

  bus_cycle_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
    .i_be(be), .i_wdata(wdata), .o_ack(ack), .o_berr(berr), .o_rdata(rdata),
    .o_busy(busy), .o_A(bus_a), .o_AS_n(as_n), .o_UDS_n(uds_n),
    .o_LDS_n(lds_n), .o_RW(rw), .o_D(bus_q), .o_D_oe(d_oe), .i_D(bus_d),
    .i_DTACK_n(dtack_n), .o_state(state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    if (!reset) begin
      chk("ack_berr_exclusive", {31'b0, ack & berr}, 32'd0);
      chk("data_strobe_without_as", {31'b0, as_n & ~(uds_n & lds_n)}, 32'd0);
      if (ack || berr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", {14'b0, ack, berr, rdata}, 32'd0);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("completion", {14'b0, ack, berr, rdata}, {14'b0, e});
        end
      end
    end
  end

  task automatic drive_req(input logic w, input logic [22:0] a, input logic [1:0] b,
                           input logic [15:0] wd);
    req = 1'b1; we = w; addr = a; be = b; wdata = wd;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  // Random cycle with DTACK arriving dly cycles after cycle 2.
  task automatic do_cycle(input logic w, input logic [22:0] a, input logic [1:0] b,
                          input logic [15:0] d, input int dly);
    int n = 0;
    drive_req(w, a, b, d);
    bus_d = d;
    if (!w) model_rdata = d;
    exp_q.push_back({1'b1, 1'b0, model_rdata});
    tick();
    req = 1'b0;
    chk("rnd_addr", {9'b0, bus_a}, {9'b0, a});
    tick(1 + dly);
    dtack_n = 1'b0;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    chk("rnd_ack_seen", {31'b0, ack}, 32'd1);
    dtack_n = 1'b1;
    wait_idle("rnd_idle", 10);
  endtask

  initial begin
    // Reset state.
    tick(2);
    chk("rst_as_n", {31'b0, as_n}, 32'd1);
    chk("rst_uds_lds", {30'b0, uds_n, lds_n}, 32'd3);
    chk("rst_rw", {31'b0, rw}, 32'd1);
    chk("rst_d_oe", {31'b0, d_oe}, 32'd0);
    chk("rst_a", {9'b0, bus_a}, 32'd0);
    chk("rst_d", {16'b0, bus_q}, 32'd0);
    chk("rst_rdata", {16'b0, rdata}, 32'd0);
    chk("rst_ack_berr_busy", {29'b0, ack, berr, busy}, 32'd0);
    chk("rst_state", {29'b0, state}, 32'd0);
    reset = 1'b0;
    tick();

    // Read: 0x700000, be=11, DTACK low from cycle 2, data 0xBEEF.
    drive_req(1'b0, 23'h700000, 2'b11, 16'h0000);
    bus_d = 16'hBEEF;
    model_rdata = 16'hBEEF;
    exp_q.push_back({1'b1, 1'b0, 16'hBEEF});
    tick(); req = 1'b0;                                          // cycle 1
    chk("rd_c1_a", {9'b0, bus_a}, 32'h700000);
    chk("rd_c1_as_rw_busy", {29'b0, as_n, rw, busy}, 32'd7);
    tick(); dtack_n = 1'b0;                                      // cycle 2
    chk("rd_c2_strobes", {29'b0, as_n, uds_n, lds_n}, 32'd0);
    tick();                                                      // cycle 3
    chk("rd_c3_as", {31'b0, as_n}, 32'd0);
    tick();                                                      // cycle 4
    chk("rd_c4_as", {31'b0, as_n}, 32'd0);
    chk("rd_c4_no_ack", {31'b0, ack}, 32'd0);
    tick();                                                      // cycle 5
    chk("rd_c5_ack", {31'b0, ack}, 32'd1);
    chk("rd_c5_rdata", {16'b0, rdata}, 32'hBEEF);
    chk("rd_c5_strobes", {29'b0, as_n, uds_n, lds_n}, 32'd7);
    dtack_n = 1'b1;
    tick();                                                      // cycle 6
    chk("rd_c6_busy", {31'b0, busy}, 32'd1);
    tick(2);                                                     // cycle 8
    chk("rd_c8_idle", {29'b0, state}, 32'd0);
    chk("rd_c8_busy", {31'b0, busy}, 32'd0);

    // Write: 0x000080, be=01, data 0x00A5.
    drive_req(1'b1, 23'h000080, 2'b01, 16'h00A5);
    exp_q.push_back({1'b1, 1'b0, model_rdata});
    tick(); req = 1'b0;                                          // cycle 1
    chk("wr_c1_rw", {31'b0, rw}, 32'd0);
    chk("wr_c1_d", {15'b0, d_oe, bus_q}, 32'h100A5);
    chk("wr_c1_strobes", {29'b0, as_n, uds_n, lds_n}, 32'd7);
    tick(); dtack_n = 1'b0;                                      // cycle 2
    chk("wr_c2_strobes", {29'b0, as_n, uds_n, lds_n}, 32'd3);
    tick();                                                      // cycle 3
    chk("wr_c3_strobes", {29'b0, as_n, uds_n, lds_n}, 32'd2);
    chk("wr_c3_d", {15'b0, d_oe, bus_q}, 32'h100A5);
    tick();                                                      // cycle 4
    chk("wr_c4_strobes", {29'b0, as_n, uds_n, lds_n}, 32'd2);
    tick();                                                      // cycle 5
    chk("wr_c5_ack", {31'b0, ack}, 32'd1);
    chk("wr_c5_d", {14'b0, rw, d_oe, bus_q}, 32'h100A5);
    chk("wr_c5_uds", {31'b0, uds_n}, 32'd1);
    chk("wr_c5_rdata_kept", {16'b0, rdata}, 32'hBEEF);
    dtack_n = 1'b1;
    tick();                                                      // cycle 6
    chk("wr_c6_oe_rw", {30'b0, d_oe, rw}, 32'd1);
    wait_idle("wr_idle", 10);

    // Timeout: DTACK never arrives.
    drive_req(1'b0, 23'h123456, 2'b10, 16'h0000);
    exp_q.push_back({1'b0, 1'b1, model_rdata});
    tick(); req = 1'b0;
    tick(9);                                                     // cycle 10
    chk("to_c10_wait", {29'b0, state}, 32'd3);
    chk("to_c10_berr", {31'b0, berr}, 32'd0);
    tick();                                                      // cycle 11
    chk("to_c11_berr_ack", {30'b0, berr, ack}, 32'd2);
    chk("to_c11_strobes", {29'b0, as_n, uds_n, lds_n}, 32'd7);
    tick(2);                                                     // cycle 13
    chk("to_c13_idle", {29'b0, state}, 32'd0);

    // Tie: dtack_s falls in the WAIT cycle where the counter reaches the limit.
    drive_req(1'b0, 23'h2AAAAA, 2'b11, 16'h0000);
    bus_d = 16'h1234;
    model_rdata = 16'h1234;
    exp_q.push_back({1'b1, 1'b0, 16'h1234});
    tick(); req = 1'b0;
    tick(7); dtack_n = 1'b0;                                     // cycle 8
    tick(3);                                                     // cycle 11
    chk("tie_ack_berr", {30'b0, ack, berr}, 32'd2);
    chk("tie_rdata", {16'b0, rdata}, 32'h1234);
    dtack_n = 1'b1;
    wait_idle("tie_idle", 10);

    // Reset while in WAIT aborts silently.
    drive_req(1'b1, 23'h055555, 2'b11, 16'hCAFE);
    tick(); req = 1'b0;
    tick(3);                                                     // cycle 4
    chk("rstw_in_wait", {29'b0, state}, 32'd3);
    reset = 1'b1;
    tick();
    chk("rstw_strobes", {29'b0, as_n, uds_n, lds_n}, 32'd7);
    chk("rstw_rw_oe_busy", {29'b0, rw, d_oe, busy}, 32'd4);
    chk("rstw_ack_berr", {30'b0, ack, berr}, 32'd0);
    reset = 1'b0;
    model_rdata = 16'h0000;
    tick(3);

    // Request with be=00 is rejected.
    drive_req(1'b0, 23'h000010, 2'b00, 16'h0000);
    exp_q.push_back({1'b0, 1'b1, model_rdata});
    tick(); req = 1'b0;                                          // cycle 1
    chk("be0_c1_berr", {31'b0, berr}, 32'd1);
    chk("be0_c1_as_busy", {30'b0, as_n, busy}, 32'd2);
    tick();
    chk("be0_c2_as_busy", {30'b0, as_n, busy}, 32'd2);

    // Randomised reads and writes with short DTACK delays.
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'($urandom_range(0, 1)), 23'($urandom_range(0, 23'h7FFFFF)),
               2'($urandom_range(1, 3)), 16'($urandom_range(0, 16'hFFFF)),
               int'($urandom_range(0, 4)));
      chk("rnd_rdata_model", {16'b0, rdata}, {16'b0, model_rdata});
    end

    tick(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
